// File: rtl/uart_arb_pkg.sv
// Shared definitions for the uart_tx arbiter.
//   - state_t   : arbiter FSM encoding (TAG exists only when UART_ARB_TAG_EN
//                 is defined)
//   - TAG_BASE  : upper nibble of the per-grant tag byte (tag = TAG_BASE | index)
//   - BURST_W   : width of the per-grant burst counter
//   - TMO_W     : width of the busy-rise timeout counter
package uart_arb_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3
`ifdef UART_ARB_TAG_EN
    , TAG     = 3'd4
`endif
  } state_t;

  localparam logic [7:0] TAG_BASE = 8'hF0;
  localparam int         BURST_W  = 8;
  localparam int         TMO_W    = 8;

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin picker (rotate / fixed-priority / rotate back).
// The request vector is rotated so that the requester after last_grant sits
// at bit 0, the lowest set bit wins, and the result is rotated back.
// Ports:
//   req        in  NUM_REQ  request vector
//   last_grant in  IDX_W    index of the previous owner
//   winner     out NUM_REQ  one-hot winner (0 when no request)
//   any_req    out 1        at least one request present
module rr_picker #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] winner,
  output logic               any_req
);

  logic [NUM_REQ-1:0] rot;
  logic [NUM_REQ-1:0] rot_win;
  logic               found;

  // last_grant + 1 + i never exceeds 2*NUM_REQ-1, so one subtraction wraps it
  function automatic int wrap(input int v);
    return (v >= NUM_REQ) ? v - NUM_REQ : v;
  endfunction

  always_comb begin
    rot     = '0;
    rot_win = '0;
    winner  = '0;
    found   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rot[i] = req[wrap(int'(last_grant) + 1 + i)];
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rot[i] && !found) begin
        rot_win[i] = 1'b1;
        found      = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rot_win[i]) winner[wrap(int'(last_grant) + 1 + i)] = 1'b1;
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx byte transmitter between NUM_REQ
// byte producers, with a bounded burst per grant and recovery when the
// transmitter never raises busy after a strobe.
// Optional feature: define UART_ARB_TAG_EN to prefix every new grant with a
// tag byte TAG_BASE | index (requester is not acked for the tag).
// Ports:
//   clock, reset_n   clock and asynchronous active-low reset
//   req_valid/data   per-requester byte offer (byte i on req_data[8i+7:8i])
//   req_ready        one-cycle accept pulse to the granted requester
//   tx_data_valid    one-cycle strobe to uart_tx
//   tx_data          byte to uart_tx, held until the next strobe
//   tx_busy          uart_tx busy
//   grant            one-hot current owner, 0 when idle
//   timeout_err      one-cycle pulse when busy never rose after a strobe
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ      = 3,
  parameter int MAX_BURST    = 4,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_data_valid,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 timeout_err
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   last_grant;
  logic [IDX_W-1:0]   grant_idx;
  logic [BURST_W-1:0] burst_cnt;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [NUM_REQ-1:0] pick;
  logic               any_req;
  logic               load_grant;
  logic               release_grant;
  logic               burst_inc;
  logic               tmo_hit;
`ifdef UART_ARB_TAG_EN
  logic               tag_phase;
`endif

  function automatic logic [IDX_W-1:0] idx_of(input logic [NUM_REQ-1:0] oh);
    idx_of = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) idx_of = IDX_W'(i);
    end
  endfunction

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req        (req_valid),
    .last_grant (last_grant),
    .winner     (pick),
    .any_req    (any_req)
  );

  // The accept pulse is tied to the payload ISSUE cycle only.
  assign req_ready = (state == ISSUE) ? grant : '0;

  always_comb begin
    state_nxt     = state;
    load_grant    = 1'b0;
    release_grant = 1'b0;
    burst_inc     = 1'b0;
    tmo_hit       = 1'b0;
    case (state)
      IDLE: begin
        if (any_req && !tx_busy) begin
          load_grant = 1'b1;
`ifdef UART_ARB_TAG_EN
          state_nxt  = TAG;
`else
          state_nxt  = ISSUE;
`endif
        end
      end
      ISSUE: state_nxt = WAIT_BUSY;
`ifdef UART_ARB_TAG_EN
      TAG:   state_nxt = WAIT_BUSY;
`endif
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_nxt = WAIT_DONE;
        end else if (tmo_cnt == TMO_W'(BUSY_TIMEOUT - 1)) begin
          // Transmitter never started: drop the byte and give up the grant.
          tmo_hit       = 1'b1;
          release_grant = 1'b1;
          state_nxt     = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
`ifdef UART_ARB_TAG_EN
          // A finished tag always continues with the owner's payload.
          if (tag_phase) begin
            state_nxt = ISSUE;
          end else
`endif
          if ((burst_cnt < BURST_W'(MAX_BURST - 1)) && req_valid[grant_idx]) begin
            burst_inc = 1'b1;
            state_nxt = ISSUE;
          end else begin
            release_grant = 1'b1;
            state_nxt     = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      last_grant    <= IDX_W'(NUM_REQ - 1);
      grant         <= '0;
      grant_idx     <= '0;
      burst_cnt     <= '0;
      tmo_cnt       <= '0;
      tx_data       <= '0;
      tx_data_valid <= 1'b0;
      timeout_err   <= 1'b0;
`ifdef UART_ARB_TAG_EN
      tag_phase     <= 1'b0;
`endif
    end else begin
      state         <= state_nxt;
      tx_data_valid <= 1'b0;
      timeout_err   <= tmo_hit;

      if (load_grant) begin
        grant     <= pick;
        grant_idx <= idx_of(pick);
        burst_cnt <= '0;
`ifdef UART_ARB_TAG_EN
        tag_phase <= 1'b1;
`endif
      end
      if (release_grant) begin
        last_grant <= grant_idx;
        grant      <= '0;
      end
      if (burst_inc) burst_cnt <= burst_cnt + 1'b1;

      if (state == ISSUE) begin
        tx_data       <= req_data[{grant_idx, 3'b000} +: 8];
        tx_data_valid <= 1'b1;
`ifdef UART_ARB_TAG_EN
        tag_phase     <= 1'b0;
`endif
      end
`ifdef UART_ARB_TAG_EN
      if (state == TAG) begin
        tx_data       <= TAG_BASE | 8'(grant_idx);
        tx_data_valid <= 1'b1;
      end
`endif

      // Counter restarts every time WAIT_BUSY is entered.
      if (state == WAIT_BUSY && !tx_busy) tmo_cnt <= tmo_cnt + 1'b1;
      else                                tmo_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  localparam int NUM_REQ      = 3;
  localparam int MAX_BURST    = 2;
  localparam int BUSY_TIMEOUT = 16;

  logic                 clock = 1'b0;
  logic                 reset_n;
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_data_valid;
  logic [7:0]           tx_data;
  logic                 tx_busy;
  logic [NUM_REQ-1:0]   grant;
  logic                 timeout_err;

  always #5 clock = ~clock;

  uart_tx_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .MAX_BURST    (MAX_BURST),
    .BUSY_TIMEOUT (BUSY_TIMEOUT)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .tx_data_valid (tx_data_valid),
    .tx_data       (tx_data),
    .tx_busy       (tx_busy),
    .grant         (grant),
    .timeout_err   (timeout_err)
  );

  int nchecks = 0;
  int nerrs   = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrs++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- transmitter busy model ----------------
  bit busy_en    = 1'b1;
  bit busy_force = 1'b0;
  int busy_len   = 4;
  int busy_left  = 0;

  always @(posedge clock) begin
    if (busy_left > 0)                  busy_left <= busy_left - 1;
    else if (busy_en && tx_data_valid)  busy_left <= busy_len;
  end
  assign tx_busy = (busy_left > 0) || busy_force;

  // ---------------- cycle counter and monitor / scoreboard ----------------
  typedef struct { int idx; logic [7:0] b; } exp_t;
  exp_t exp_q[$];

  int cyc = 0;
  int strobe_cnt = 0, last_strobe_cyc = 0;
  int tmo_seen = 0, last_tmo_cyc = 0;
  int ack_cnt[NUM_REQ];
  int last_ack_cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (tx_data_valid) begin
      exp_t e;
      strobe_cnt++;
      last_strobe_cyc = cyc;
      chk("sb_nonempty", 32'(exp_q.size() > 0), 32'(1));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("tx_data", 32'(tx_data), 32'(e.b));
        chk("strobe_grant", 32'(grant), 32'(1) << e.idx);
      end
    end
    if (|req_ready) begin
      chk("ack_valid", 32'(req_ready & ~req_valid), 32'(0));
      chk("ack_grant", 32'(req_ready), 32'(grant));
      for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) ack_cnt[i]++;
      last_ack_cyc = cyc;
    end
    if (timeout_err) begin
      tmo_seen++;
      last_tmo_cyc = cyc;
      chk("tmo_grant_idle", 32'(grant), 32'(0));
    end
  end

  // ---------------- requester models ----------------
  logic [7:0] src_q[NUM_REQ][$];

  task automatic drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i]       = (src_q[i].size() > 0);
      req_data[8*i +: 8] = (src_q[i].size() > 0) ? src_q[i][0] : 8'h00;
    end
  endtask

  task automatic load(input int i, input logic [7:0] b);
    src_q[i].push_back(b);
    drive();
  endtask

  task automatic push_exp(input int i, input logic [7:0] b, input bit new_grant);
`ifdef UART_ARB_TAG_EN
    if (new_grant) exp_q.push_back('{i, 8'hF0 | 8'(i)});
`endif
    exp_q.push_back('{i, b});
  endtask

  task automatic tick();
    logic [NUM_REQ-1:0] rs;
    @(negedge clock);
    rs = req_ready;
    @(posedge clock);
    #1;
    for (int i = 0; i < NUM_REQ; i++)
      if (rs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    drive();
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (!(src_q[0].size() == 0 && src_q[1].size() == 0 && src_q[2].size() == 0 &&
             exp_q.size() == 0 && grant == '0 && !tx_busy) && n < budget) begin
      tick();
      n++;
    end
    chk(name, 32'(n < budget), 32'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  typedef struct { int idx; logic [7:0] data; int blen; int exp_lat; } vec_t;
  vec_t vecs[4];

  initial begin
    int s0, a0, a1, a2, t0, dc, n, sc;

    vecs[0] = '{0, 8'h41, 60, 2};
    vecs[1] = '{1, 8'h00, 3, 2};
    vecs[2] = '{0, 8'hA5, 1, 2};
    vecs[3] = '{2, 8'hFF, 5, 2};

    reset_n   = 1'b0;
    req_valid = '0;
    req_data  = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'(0));
    chk("rst_tx_valid", 32'(tx_data_valid), 32'(0));
    chk("rst_tx_data", 32'(tx_data), 32'(0));
    chk("rst_grant", 32'(grant), 32'(0));
    chk("rst_timeout", 32'(timeout_err), 32'(0));
    reset_n = 1'b1;

    // Single-requester vectors: latency, one ack, grant returns to 0.
    for (int v = 0; v < 4; v++) begin
      busy_len = vecs[v].blen;
      s0 = strobe_cnt;
      a0 = ack_cnt[vecs[v].idx];
      push_exp(vecs[v].idx, vecs[v].data, 1'b1);
      load(vecs[v].idx, vecs[v].data);
      dc = cyc;
      n = 0;
      while (strobe_cnt == s0 && n < 20) begin tick(); n++; end
      chk("vec_latency", 32'(last_strobe_cyc - dc), 32'(vecs[v].exp_lat));
      wait_idle("vec_done", 300);
      chk("vec_acks", 32'(ack_cnt[vecs[v].idx] - a0), 32'(1));
      chk("vec_grant_idle", 32'(grant), 32'(0));
    end

    // All requesters continuously valid: bursts of MAX_BURST in rotation.
    busy_len = 2;
    a0 = ack_cnt[0]; a1 = ack_cnt[1]; a2 = ack_cnt[2];
    for (int r = 0; r < 2; r++)
      for (int g = 0; g < NUM_REQ; g++)
        for (int j = 0; j < MAX_BURST; j++)
          push_exp(g, 8'(16 * g + 2 * r + j), j == 0);
    for (int g = 0; g < NUM_REQ; g++)
      for (int k = 0; k < 4; k++) load(g, 8'(16 * g + k));
    wait_idle("rr_done", 400);
    chk("rr_acks0", 32'(ack_cnt[0] - a0), 32'(4));
    chk("rr_acks1", 32'(ack_cnt[1] - a1), 32'(4));
    chk("rr_acks2", 32'(ack_cnt[2] - a2), 32'(4));

    // Requester 1 has a single byte: its burst ends early and r2 follows.
    a1 = ack_cnt[1]; a2 = ack_cnt[2];
    push_exp(1, 8'hB1, 1'b1);
    push_exp(2, 8'hC0, 1'b1);
    push_exp(2, 8'hC1, 1'b0);
    load(1, 8'hB1);
    load(2, 8'hC0);
    load(2, 8'hC1);
    wait_idle("drop_done", 300);
    chk("drop_acks1", 32'(ack_cnt[1] - a1), 32'(1));
    chk("drop_acks2", 32'(ack_cnt[2] - a2), 32'(2));

    // Transmitter never goes busy: timeout, then the next requester.
    busy_en = 1'b0;
    s0 = strobe_cnt; t0 = tmo_seen;
    a0 = ack_cnt[0]; a1 = ack_cnt[1];
`ifdef UART_ARB_TAG_EN
    exp_q.push_back('{0, 8'hF0});
    push_exp(1, 8'h88, 1'b1);
    push_exp(0, 8'h77, 1'b1);
`else
    push_exp(0, 8'h77, 1'b1);
    push_exp(1, 8'h88, 1'b1);
`endif
    load(0, 8'h77);
    load(1, 8'h88);
    n = 0;
    while (strobe_cnt == s0 && n < 20) begin tick(); n++; end
    sc = last_strobe_cyc;
    n = 0;
    while (tmo_seen == t0 && n < 60) begin tick(); n++; end
    chk("tmo_seen", 32'(tmo_seen - t0), 32'(1));
    chk("tmo_latency", 32'(last_tmo_cyc - sc), 32'(BUSY_TIMEOUT));
    busy_en = 1'b1;
    wait_idle("tmo_recover", 300);
    chk("tmo_single_pulse", 32'(tmo_seen - t0), 32'(1));
    chk("tmo_acks0", 32'(ack_cnt[0] - a0), 32'(1));
    chk("tmo_acks1", 32'(ack_cnt[1] - a1), 32'(1));

    // Transmitter busy while idle: arbitration is held off.
    busy_force = 1'b1;
    s0 = strobe_cnt;
    push_exp(2, 8'h3C, 1'b1);
    load(2, 8'h3C);
    repeat (6) tick();
    chk("holdoff_strobes", 32'(strobe_cnt - s0), 32'(0));
    chk("holdoff_grant", 32'(grant), 32'(0));
    busy_force = 1'b0;
    wait_idle("holdoff_done", 100);

    // Reset while waiting for the transmitter to finish.
    busy_len = 20;
`ifdef UART_ARB_TAG_EN
    exp_q.push_back('{0, 8'hF0});
`else
    exp_q.push_back('{0, 8'hAA});
`endif
    load(0, 8'hAA);
    load(0, 8'hAB);
    n = 0;
    while (!(grant != '0 && tx_busy) && n < 30) begin tick(); n++; end
    chk("rst_reach_wait_done", 32'(n < 30), 32'(1));
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_req_ready", 32'(req_ready), 32'(0));
    chk("midrst_tx_valid", 32'(tx_data_valid), 32'(0));
    chk("midrst_tx_data", 32'(tx_data), 32'(0));
    chk("midrst_grant", 32'(grant), 32'(0));
    chk("midrst_timeout", 32'(timeout_err), 32'(0));
    for (int i = 0; i < NUM_REQ; i++) src_q[i].delete();
    exp_q.delete();
    drive();
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    s0 = strobe_cnt;
    repeat (8) tick();
    chk("postrst_no_strobe", 32'(strobe_cnt - s0), 32'(0));
    busy_len = 3;
    push_exp(1, 8'h5A, 1'b1);
    load(1, 8'h5A);
    wait_idle("postrst_done", 200);

`ifdef UART_ARB_TAG_EN
    // Tag then payload; the requester is acked only for the payload.
    a2 = ack_cnt[2];
    s0 = strobe_cnt;
    push_exp(2, 8'h55, 1'b1);
    load(2, 8'h55);
    n = 0;
    while (strobe_cnt == s0 && n < 20) begin tick(); n++; end
    sc = last_strobe_cyc;
    wait_idle("tag_done", 200);
    chk("tag_acks2", 32'(ack_cnt[2] - a2), 32'(1));
    chk("tag_ack_after_tag", 32'(last_ack_cyc > sc), 32'(1));
`endif

    $display("Result: errors=%0d of %0d checks", nerrs, nchecks);
    $finish;
  end

endmodule
